// File: rtl/io_pkg.sv
// Shared constants and types for the switch input-conditioning stage.
// The debounce feature is enabled by defining IO_SW_DEBOUNCE_EN.
package io_pkg;

   localparam int IO_SW_WIDTH             = 32;
   localparam int DEFAULT_NUM_SW          = 18;
   localparam int DEFAULT_SYNC_STAGES     = 2;
   // 10 ms at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

   typedef enum logic {
      DB_STABLE = 1'b0,
      DB_COUNT  = 1'b1
   } debounce_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: multi-flop synchroniser followed by a debounce FSM.
// With IO_SW_DEBOUNCE_EN defined, a change is committed only after
// DEBOUNCE_CYCLES+1 consecutive cycles where the synchronised input differs
// from the committed value. Without it, the synchronised input is simply
// registered. o_state exposes the FSM state for observation.
module sw_debounce_bit
   import io_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_raw,
   output logic            o_sw,
   output logic            o_edge,
   output debounce_state_e o_state
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;

   // Shift the asynchronous pin through the synchroniser chain.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], i_raw};
      end
   end

   assign s = sync[SYNC_STAGES-1];

`ifdef IO_SW_DEBOUNCE_EN
   localparam int             CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  COUNT_MAX = CW'(DEBOUNCE_CYCLES);

   debounce_state_e state;
   logic [CW-1:0]   count;

   // Debounce FSM: count consecutive mismatches, commit when the run is long
   // enough, abandon the run on any bounce back. The counter stops at
   // COUNT_MAX because reaching it always commits and clears it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= DB_STABLE;
         count  <= '0;
         o_sw   <= 1'b0;
         o_edge <= 1'b0;
      end else begin
         o_edge <= 1'b0;
         case (state)
            DB_STABLE: begin
               if (s != o_sw) begin
                  state <= DB_COUNT;
                  count <= CW'(1);
               end else begin
                  count <= '0;
               end
            end
            DB_COUNT: begin
               if (s == o_sw) begin
                  state <= DB_STABLE;
                  count <= '0;
               end else if (count == COUNT_MAX) begin
                  o_sw   <= s;
                  o_edge <= 1'b1;
                  state  <= DB_STABLE;
                  count  <= '0;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: begin
               state <= DB_STABLE;
               count <= '0;
            end
         endcase
      end
   end

   assign o_state = state;
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   // Plain registered copy of the synchronised bit with a change pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_sw   <= 1'b0;
         o_edge <= 1'b0;
      end else begin
         o_sw   <= s;
         o_edge <= s ^ o_sw;
      end
   end

   assign o_state = DB_STABLE;
`endif

endmodule

// File: rtl/io_sw_conditioner.sv
// Switch input conditioner feeding the processor's i_io_sw port.
// Instantiates one sw_debounce_bit per physical switch and assembles the
// 32-bit switch and edge words; bits above NUM_SW are constant zero.
// Debouncing is enabled by defining IO_SW_DEBOUNCE_EN.
module io_sw_conditioner
   import io_pkg::*;
#(
   parameter int NUM_SW          = DEFAULT_NUM_SW,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [IO_SW_WIDTH-1:0] i_sw_raw,
   output logic [IO_SW_WIDTH-1:0] o_io_sw,
   output logic [IO_SW_WIDTH-1:0] o_sw_edge,
   output logic                   o_sw_changed
);

   logic [NUM_SW-1:0] sw_bits;
   logic [NUM_SW-1:0] edge_bits;
   debounce_state_e   unused_db_state [NUM_SW];
   logic              unused_raw;

   // Pins above NUM_SW have no logic behind them.
   assign unused_raw = ^i_sw_raw;

   // One independent conditioner per physical switch.
   for (genvar b = 0; b < NUM_SW; b++) begin : g_bit
      sw_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_raw   (i_sw_raw[b]),
         .o_sw    (sw_bits[b]),
         .o_edge  (edge_bits[b]),
         .o_state (unused_db_state[b])
      );
   end

   assign o_io_sw      = IO_SW_WIDTH'(sw_bits);
   assign o_sw_edge    = IO_SW_WIDTH'(edge_bits);
   assign o_sw_changed = |edge_bits;

endmodule
